// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, device ACK check.
// Optional automatic retry of NACK / transfer-timeout failures is enabled by defining PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ      = 74_250_000,
  parameter int INHIBIT_US       = 100,
  parameter int SETUP_US         = 5,
  parameter int START_TIMEOUT_US = 15000,
  parameter int XFER_TIMEOUT_US  = 2000,
  parameter int MAX_RETRIES      = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tx_valid_in,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out,
  output logic [1:0] err_code_out
);

  // state     | meaning
  // S_IDLE    | ready for a byte, lines released
  // S_INHIBIT | clock held low
  // S_REQUEST | clock and data held low (start bit)
  // S_SHIFT   | device clocks the frame, host drives bits on falls
  // S_WAIT_IDLE | ACK seen, wait for both lines high
  // S_DONE / S_ERR | one-cycle result pulse, lines released
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQUEST, S_SHIFT, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  localparam int C_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int C_INH    = C_PER_US * INHIBIT_US;
  localparam int C_SET    = C_PER_US * SETUP_US;
  localparam int C_START  = C_PER_US * START_TIMEOUT_US;
  localparam int C_XFER   = C_PER_US * XFER_TIMEOUT_US;
  localparam int C_MAX_A  = (C_INH > C_SET) ? C_INH : C_SET;
  localparam int C_MAX_B  = (C_START > C_XFER) ? C_START : C_XFER;
  localparam int C_MAX    = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int CW       = $clog2(C_MAX);
  localparam int RW       = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [1:0] E_START = 2'b01;
  localparam logic [1:0] E_XFER  = 2'b10;
  localparam logic [1:0] E_NACK  = 2'b11;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_clk_sync, r_data_sync;
  logic            r_clk_prev;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_n;
  logic [7:0]      r_byte, r_shreg;
  logic            r_par;
  logic            r_data_oe;
  logic [1:0]      r_err_code;
  logic [RW-1:0]   r_retry;

  logic            w_clk_s, w_data_s, w_fall, w_tc, w_accept;
  logic [3:0]      w_n_nxt;
  logic            w_fail, w_retry;
  logic [1:0]      w_fail_code;

  assign w_clk_s  = r_clk_sync[1];
  assign w_data_s = r_data_sync[1];
  assign w_fall   = r_clk_prev & ~w_clk_s;
  assign w_tc     = (r_cnt == '0);
  assign w_accept = tx_valid_in & (r_state == S_IDLE);
  assign w_n_nxt  = r_n + 4'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
    w_retry     = 1'b0;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_INHIBIT;
      S_INHIBIT:   if (w_tc) w_state_nxt = S_REQUEST;
      S_REQUEST:   if (w_tc) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        // a fall in the same cycle as counter expiry takes priority
        if (w_fall) begin
          if (w_n_nxt == 4'd11) begin
            if (w_data_s) begin
              w_fail      = 1'b1;
              w_fail_code = E_NACK;
            end else begin
              w_state_nxt = S_WAIT_IDLE;
            end
          end
        end else if (w_tc) begin
          w_fail      = 1'b1;
          w_fail_code = (r_n == 4'd0) ? E_START : E_XFER;
        end
        w_retry = RETRY_EN && (w_fail_code != E_START) && (r_retry < RW'(MAX_RETRIES));
        if (w_fail) w_state_nxt = w_retry ? S_INHIBIT : S_ERR;
      end
      S_WAIT_IDLE: if (w_clk_s & w_data_s) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      S_ERR:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_cnt       <= '0;
      r_n         <= 4'd0;
      r_byte      <= 8'h00;
      r_shreg     <= 8'h00;
      r_par       <= 1'b0;
      r_data_oe   <= 1'b0;
      r_err_code  <= 2'b00;
      r_retry     <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
      r_data_sync <= {r_data_sync[0], ps2_data_in};
      r_clk_prev  <= w_clk_s;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_byte     <= tx_data_in;
          r_shreg    <= tx_data_in;
          r_par      <= ~^tx_data_in;
          r_cnt      <= CW'(C_INH - 1);
          r_retry    <= '0;
          r_err_code <= 2'b00;
        end
        S_INHIBIT: r_cnt <= w_tc ? CW'(C_SET - 1) : r_cnt - 1'b1;
        S_REQUEST: begin
          if (w_tc) begin
            r_cnt     <= CW'(C_START - 1);
            r_n       <= 4'd0;
            r_data_oe <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_n <= w_n_nxt;
            if (r_n == 4'd0)  r_cnt <= CW'(C_XFER - 1);
            else if (!w_tc)   r_cnt <= r_cnt - 1'b1;
            if (w_n_nxt <= 4'd8) begin
              r_data_oe <= ~r_shreg[0];
              r_shreg   <= {1'b0, r_shreg[7:1]};
            end else if (w_n_nxt == 4'd9) begin
              r_data_oe <= ~r_par;
            end else if (w_n_nxt == 4'd10) begin
              r_data_oe <= 1'b0;
            end
          end else if (!w_tc) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (w_fail) begin
            r_data_oe <= 1'b0;
            if (w_retry) begin
              r_retry <= r_retry + 1'b1;
              r_shreg <= r_byte;
              r_cnt   <= CW'(C_INH - 1);
            end else begin
              r_err_code <= w_fail_code;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ps2_clk_oe   = (r_state == S_INHIBIT) || (r_state == S_REQUEST);
    ps2_data_oe  = (r_state == S_REQUEST) || ((r_state == S_SHIFT) && r_data_oe);
    busy_out     = (r_state != S_IDLE);
    tx_ready_out = (r_state == S_IDLE);
    done_out     = (r_state == S_DONE);
    err_out      = (r_state == S_ERR);
    err_code_out = r_err_code;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx at 1 MHz (1 cycle = 1 us) with a 50-cycle-period device clock model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic [1:0] err_code;
  wire        ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.CLK_FREQ_HZ(1_000_000)) u_dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .tx_valid_in  (tx_valid),
    .tx_data_in   (tx_data),
    .tx_ready_out (tx_ready),
    .ps2_clk_in   (ps2_clk_pin),
    .ps2_data_in  (ps2_data_pin),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_data_oe  (ps2_data_oe),
    .busy_out     (busy),
    .done_out     (done),
    .err_out      (err),
    .err_code_out (err_code)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, frame_cnt = 0, err_cyc = 0;
  logic [1:0] last_code = 2'b00;
  logic       prev_req = 1'b0;
  int         e1_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      last_code <= err_code;
      err_cyc   <= cyc;
    end
    if (ps2_clk_oe && ps2_data_oe && !prev_req) frame_cnt <= frame_cnt + 1;
    prev_req <= ps2_clk_oe && ps2_data_oe;
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic measure_req(output int n_inh, output int n_req);
    n_inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 1000) begin
      n_inh++;
      @(negedge clk);
    end
    n_req = 0;
    while (ps2_clk_oe && ps2_data_oe && n_req < 1000) begin
      n_req++;
      @(negedge clk);
    end
  endtask

  task automatic dev_clock(input int n_edges, input bit ack,
                           output logic [10:1] oe_seq, output logic [10:1] line);
    int t = 0;
    oe_seq = '0;
    line   = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("dev_rts_wait", 0, 1);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) dev_data_low = 1'b1;
      if (k == 1) e1_cyc = cyc;
      dev_clk_low = 1'b1;
      repeat (25) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) begin
        repeat (24) @(negedge clk);
        oe_seq[k] = ps2_data_oe;
        line[k]   = ps2_data_pin;
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int d0, input int lim, input string tag);
    int t = 0;
    while (done_cnt == d0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (t >= lim) check(tag, 0, 1);
  endtask

  task automatic wait_err(input int e0, input int lim, input string tag);
    int t = 0;
    while (err_cnt == e0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (t >= lim) check(tag, 0, 1);
  endtask

  initial begin
    int          n_inh, n_req, d0, e0, f0, rel, dlt, n_frames;
    logic [10:1] seq, line;

    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    check("ed_busy", busy, 1);
    check("ed_ready", tx_ready, 0);
    measure_req(n_inh, n_req);
    check("ed_inhibit_len", n_inh, 100);
    check("ed_request_len", n_req, 5);
    dev_clock(11, 1'b1, seq, line);
    check("ed_oe_seq", seq, 10'h012);
    check("ed_byte", line[8:1], 8'hED);
    check("ed_parity", line[9], 1);
    check("ed_stop", line[10], 1);
    wait_done(d0, 200, "ed_done_wait");
    repeat (10) @(negedge clk);
    check("ed_done_cnt", done_cnt - d0, 1);
    check("ed_err_cnt", err_cnt - e0, 0);
    check("ed_ready_after", tx_ready, 1);

    // 0x00 with ACK; tx_valid pulsed while busy must not start a second frame
    d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
    send(8'h00);
    measure_req(n_inh, n_req);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_clock(11, 1'b1, seq, line);
    check("z_oe_edge9", seq[9], 0);
    check("z_oe_seq", seq, 10'h0FF);
    check("z_byte", line[8:1], 8'h00);
    check("z_parity", line[9], 1);
    wait_done(d0, 200, "z_done_wait");
    repeat (300) @(negedge clk);
    check("z_done_cnt", done_cnt - d0, 1);
    check("z_frames", frame_cnt - f0, 1);
    check("z_busy_after", busy, 0);

    // device never clocks
    e0 = err_cnt;
    send(8'h55);
    measure_req(n_inh, n_req);
    rel = cyc;
    wait_err(e0, 16000, "st_err_wait");
    @(negedge clk);
    check("st_code", last_code, 2'b01);
    check("st_err_time", err_cyc - rel, 15000);
    check("st_clk_oe", ps2_clk_oe, 0);
    check("st_data_oe", ps2_data_oe, 0);
    repeat (50) @(negedge clk);
    check("st_code_held", err_code, 2'b01);
    check("st_err_cnt", err_cnt - e0, 1);

    // device NACKs
`ifdef PS2_TX_RETRY_EN
    n_frames = 3;
`else
    n_frames = 1;
`endif
    d0 = done_cnt; e0 = err_cnt; f0 = frame_cnt;
    send(8'h12);
    measure_req(n_inh, n_req);
    for (int f = 0; f < n_frames; f++) dev_clock(11, 1'b0, seq, line);
    wait_err(e0, 3000, "nack_err_wait");
    repeat (5) @(negedge clk);
    check("nack_code", last_code, 2'b11);
    check("nack_frames", frame_cnt - f0, n_frames);
    check("nack_err_cnt", err_cnt - e0, 1);
    check("nack_done_cnt", done_cnt - d0, 0);

    // device stops after edge 4
    e0 = err_cnt; f0 = frame_cnt;
    send(8'h34);
    measure_req(n_inh, n_req);
    dev_clock(4, 1'b0, seq, line);
`ifdef PS2_TX_RETRY_EN
    wait_err(e0, 20000, "xt_err_wait");
    repeat (5) @(negedge clk);
    check("xt_code_retry", last_code, 2'b01);
    check("xt_frames", frame_cnt - f0, 2);
`else
    wait_err(e0, 3000, "xt_err_wait");
    repeat (5) @(negedge clk);
    dlt = err_cyc - e1_cyc;
    check("xt_code", last_code, 2'b10);
    check("xt_err_time", (dlt >= 2000 && dlt <= 2005), 1);
    check("xt_frames", frame_cnt - f0, 1);
`endif
    check("xt_data_oe", ps2_data_oe, 0);

    // reset in the middle of SHIFT
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A);
    measure_req(n_inh, n_req);
    repeat (20) @(negedge clk);
    check("rs_pre_data_oe", ps2_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rs_clk_oe", ps2_clk_oe, 0);
    check("rs_data_oe", ps2_data_oe, 0);
    check("rs_busy", busy, 0);
    check("rs_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rs_done_cnt", done_cnt - d0, 0);
    check("rs_err_cnt", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
